// File: rtl/deserializer.sv
// MSB-first serial-to-parallel receiver with a single valid/ready holding register.
// Optional dropped-frame counter (err_cnt_o) enabled by defining DESER_ERR_CNT_EN.
module deserializer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    input  logic              busy_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  data_mod_o,
    output logic              data_val_o,
    input  logic              data_rdy_i,
`ifdef DESER_ERR_CNT_EN
    output logic [7:0]        err_cnt_o,
`endif
    output logic              ovf_o
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;

    logic              close_c;
    logic [DATA_W-1:0] close_word_c;
    logic [CNT_W-1:0]  close_cnt_c;
    logic [DATA_W-1:0] sr_shift_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              pop_c;
    logic              load_c;
    logic              drop_c;

    // Collector state register
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    // Collector next state and frame-close detection; a full word wins over busy
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        close_c      = 1'b0;
        close_word_c = '0;
        close_cnt_c  = '0;
        sr_shift_c   = {sr_q[DATA_W-2:0], ser_data_i};
        cnt_inc_c    = CNT_W'(cnt_q + 1'b1);

        if (ser_data_val_i) begin
            if (cnt_inc_c == CNT_W'(DATA_W)) begin
                close_c      = 1'b1;
                close_word_c = sr_shift_c;
                close_cnt_c  = cnt_inc_c;
                state_d      = IDLE;
                cnt_d        = '0;
                sr_d         = '0;
            end else begin
                state_d = COLLECT;
                cnt_d   = cnt_inc_c;
                sr_d    = sr_shift_c;
            end
        end else if ((state_q == COLLECT) && !busy_i) begin
            close_c      = 1'b1;
            close_word_c = sr_q << (DATA_W - 32'(cnt_q));
            close_cnt_c  = cnt_q;
            state_d      = IDLE;
            cnt_d        = '0;
            sr_d         = '0;
        end
    end

    assign pop_c  = data_val_o & data_rdy_i;
    assign load_c = close_c & (~data_val_o | pop_c);
    assign drop_c = close_c & data_val_o & ~data_rdy_i;

    // Holding register; a pop in the close cycle frees the slot for the new word
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            data_o     <= '0;
            data_mod_o <= '0;
            data_val_o <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            ovf_o <= drop_c;
            if (load_c) begin
                data_o     <= close_word_c;
                data_mod_o <= close_cnt_c;
                data_val_o <= 1'b1;
            end else if (pop_c) begin
                data_val_o <= 1'b0;
            end
        end
    end

`ifdef DESER_ERR_CNT_EN
    // Saturating dropped-frame counter
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            err_cnt_o <= '0;
        end else if (drop_c && (err_cnt_o != 8'hFF)) begin
            err_cnt_o <= 8'(err_cnt_o + 8'd1);
        end
    end
`endif

endmodule
